// File: rtl/gf_op_sequencer_if.sv
// gf_op_sequencer_if: request/result handshake bundle between issue logic and gf_op_sequencer.
`default_nettype none

interface gf_op_sequencer_if #(
  parameter int DATA_WIDTH = 32
);
  localparam int GW = $clog2(DATA_WIDTH) + 1;

  logic                  in_valid;
  logic                  in_ready;
  logic [1:0]            in_op;
  logic [DATA_WIDTH-1:0] in_a;
  logic [DATA_WIDTH-1:0] in_b;
  logic [DATA_WIDTH:0]   in_poly;
  logic [GW-1:0]         in_grade;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_carry;
  logic                  out_err;

  modport master (
    output in_valid, in_op, in_a, in_b, in_poly, in_grade, out_ready,
    input  in_ready, out_valid, out_data, out_carry, out_err
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_poly, in_grade, out_ready,
    output in_ready, out_valid, out_data, out_carry, out_err
  );
endinterface

`default_nettype wire

// File: rtl/gf_op_sequencer.sv
// gf_op_sequencer: sequences a shared add/GF datapath (product pass then reduction pass) for GF(2^m) ops.
// Optional feature macro GF_SEQ_PERF_CNT_EN adds the op_count result-handshake counter output.
`default_nettype none

module gf_op_sequencer #(
  parameter int  DATA_WIDTH = 32,
  localparam int GW = $clog2(DATA_WIDTH) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  gf_op_sequencer_if.slave        bus,
  output logic                    dp_sum_funct,
  output logic                    dp_exp_funct,
  output logic                    dp_red_funct,
  output logic                    dp_carry_option,
  output logic [DATA_WIDTH-1:0]   dp_a,
  output logic [DATA_WIDTH-1:0]   dp_b,
  output logic [GW-1:0]           dp_polyn_grade,
  output logic [DATA_WIDTH:0]     dp_polyn_red_in,
  output logic [2*DATA_WIDTH-1:0] dp_reduc_in,
  input  logic [DATA_WIDTH-1:0]   dp_out,
  input  logic [DATA_WIDTH-1:0]   dp_out_poly,
  input  logic [2*DATA_WIDTH-1:0] dp_mult_out,
  input  logic                    dp_sum_carry_out
`ifdef GF_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]             op_count
`endif
);

  localparam logic [GW-1:0] MIN_GRADE = GW'(2);
  localparam logic [GW-1:0] MAX_GRADE = GW'(DATA_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXEC   = 2'd1,
    S_REDUCE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [1:0]              op_q, op_d;
  logic [DATA_WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [DATA_WIDTH:0]     poly_q, poly_d;
  logic [GW-1:0]           grade_q, grade_d;
  logic [DATA_WIDTH-1:0]   res_q, res_d;
  logic [2*DATA_WIDTH-1:0] prod_q, prod_d;
  logic                    carry_q, carry_d;
  logic                    err_q, err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      poly_q  <= '0;
      grade_q <= '0;
      res_q   <= '0;
      prod_q  <= '0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      poly_q  <= poly_d;
      grade_q <= grade_d;
      res_q   <= res_d;
      prod_q  <= prod_d;
      carry_q <= carry_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    op_d            = op_q;
    a_d             = a_q;
    b_d             = b_q;
    poly_d          = poly_q;
    grade_d         = grade_q;
    res_d           = res_q;
    prod_d          = prod_q;
    carry_d         = carry_q;
    err_d           = err_q;
    dp_sum_funct    = 1'b0;
    dp_exp_funct    = 1'b0;
    dp_red_funct    = 1'b0;
    dp_carry_option = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          op_d    = bus.in_op;
          a_d     = bus.in_a;
          b_d     = bus.in_b;
          poly_d  = bus.in_poly;
          grade_d = bus.in_grade;
          carry_d = 1'b0;
          err_d   = 1'b0;
          // Only field ops care about the grade; a bad one short-circuits to an error result.
          if (bus.in_op[1] && ((bus.in_grade < MIN_GRADE) || (bus.in_grade > MAX_GRADE))) begin
            res_d   = '0;
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_EXEC;
          end
        end
      end

      S_EXEC: begin
        case (op_q)
          2'b00: begin
            dp_sum_funct    = 1'b1;
            dp_carry_option = 1'b1;
            res_d           = dp_out;
            carry_d         = dp_sum_carry_out;
            state_d         = S_DONE;
          end
          2'b01: begin
            dp_sum_funct = 1'b1;
            res_d        = dp_out;
            carry_d      = 1'b0;
            state_d      = S_DONE;
          end
          default: begin
            dp_exp_funct = op_q[0];
            prod_d       = dp_mult_out;
            state_d      = S_REDUCE;
          end
        endcase
      end

      S_REDUCE: begin
        dp_red_funct = 1'b1;
        res_d        = dp_out_poly;
        carry_d      = 1'b0;
        state_d      = S_DONE;
      end

      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.out_data  = res_q;
  assign bus.out_carry = carry_q;
  assign bus.out_err   = err_q;

  assign dp_a            = a_q;
  assign dp_b            = b_q;
  assign dp_polyn_grade  = grade_q;
  assign dp_polyn_red_in = poly_q;
  assign dp_reduc_in     = prod_q;

`ifdef GF_SEQ_PERF_CNT_EN
  logic [31:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if ((state_q == S_DONE) && bus.out_ready) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign op_count = cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_gf_op_sequencer.sv
// tb_gf_op_sequencer: directed bench for gf_op_sequencer at DATA_WIDTH=8 with a behavioural datapath.
`default_nettype none

module tb_gf_op_sequencer;
  localparam int W  = 8;
  localparam int GW = $clog2(W) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gf_op_sequencer_if #(.DATA_WIDTH(W)) bus ();

  logic            dp_sum_funct, dp_exp_funct, dp_red_funct, dp_carry_option;
  logic [W-1:0]    dp_a, dp_b;
  logic [GW-1:0]   dp_polyn_grade;
  logic [W:0]      dp_polyn_red_in;
  logic [2*W-1:0]  dp_reduc_in;
  logic [W-1:0]    dp_out, dp_out_poly;
  logic [2*W-1:0]  dp_mult_out;
  logic            dp_sum_carry_out;
`ifdef GF_SEQ_PERF_CNT_EN
  logic [31:0]     op_count;
`endif

  gf_op_sequencer #(.DATA_WIDTH(W)) dut (
    .clk              (clk),
    .rst              (rst),
    .bus              (bus),
    .dp_sum_funct     (dp_sum_funct),
    .dp_exp_funct     (dp_exp_funct),
    .dp_red_funct     (dp_red_funct),
    .dp_carry_option  (dp_carry_option),
    .dp_a             (dp_a),
    .dp_b             (dp_b),
    .dp_polyn_grade   (dp_polyn_grade),
    .dp_polyn_red_in  (dp_polyn_red_in),
    .dp_reduc_in      (dp_reduc_in),
    .dp_out           (dp_out),
    .dp_out_poly      (dp_out_poly),
    .dp_mult_out      (dp_mult_out),
    .dp_sum_carry_out (dp_sum_carry_out)
`ifdef GF_SEQ_PERF_CNT_EN
    ,
    .op_count         (op_count)
`endif
  );

  function automatic logic [2*W-1:0] clmul(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W-1:0] p;
    p = '0;
    for (int i = 0; i < W; i++)
      if (y[i]) p = p ^ ({{W{1'b0}}, x} << i);
    return p;
  endfunction

  function automatic logic [W-1:0] clred(input logic [2*W-1:0] p, input logic [W:0] poly,
                                         input logic [GW-1:0] g);
    logic [2*W-1:0] r;
    r = p;
    for (int i = 2*W-1; i >= 0; i--)
      if ((i >= int'(g)) && r[i]) r = r ^ ({{(W-1){1'b0}}, poly} << (i - int'(g)));
    return r[W-1:0];
  endfunction

  // Datapath model: results appear only when the matching mode control is set.
  logic [W:0] add_full;
  always_comb begin
    add_full         = {1'b0, dp_a} + {1'b0, dp_b};
    dp_out           = dp_sum_funct ? (dp_carry_option ? add_full[W-1:0] : (dp_a ^ dp_b)) : '0;
    dp_sum_carry_out = dp_sum_funct & dp_carry_option & add_full[W];
    dp_mult_out      = dp_exp_funct ? clmul(dp_a, dp_a) : clmul(dp_a, dp_b);
    dp_out_poly      = dp_red_funct ? clred(dp_reduc_in, dp_polyn_red_in, dp_polyn_grade) : '0;
  end

  int total = 0;
  int bad   = 0;

  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [GW-1:0] g, output int lat);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_poly  = 9'h11B;
    bus.in_grade = g;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_a     = 8'hAA;
    bus.in_b     = 8'h55;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      if (bus.out_valid) begin
        lat = k;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic finish_hs();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    total++; if ({bus.out_err, bus.out_carry, bus.out_data} !== 10'h0) begin bad++; $display("FAIL reset_outputs got=%h exp=0", {bus.out_err, bus.out_carry, bus.out_data}); end
    total++; if ({dp_sum_funct, dp_exp_funct, dp_red_funct, dp_carry_option} !== 4'b0) begin bad++; $display("FAIL reset_dp_ctrl got=%b exp=0000", {dp_sum_funct, dp_exp_funct, dp_red_funct, dp_carry_option}); end
`ifdef GF_SEQ_PERF_CNT_EN
    total++; if (op_count !== 32'd0) begin bad++; $display("FAIL reset_op_count got=%0d exp=0", op_count); end
`endif
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_mul();
    int lat;
    issue(2'b10, 8'h57, 8'h83, 4'd8, lat);
    total++; if (lat !== 3) begin bad++; $display("FAIL mul_latency got=%0d exp=3", lat); end
    total++; if (bus.out_data !== 8'hC1) begin bad++; $display("FAIL mul_data got=%h exp=c1", bus.out_data); end
    total++; if ({bus.out_carry, bus.out_err} !== 2'b00) begin bad++; $display("FAIL mul_flags got=%b exp=00", {bus.out_carry, bus.out_err}); end
    finish_hs();
  endtask

  task automatic test_square();
    int lat;
    issue(2'b11, 8'h80, 8'hFF, 4'd8, lat);
    total++; if (lat !== 3) begin bad++; $display("FAIL sq80_latency got=%0d exp=3", lat); end
    total++; if (bus.out_data !== 8'h9A) begin bad++; $display("FAIL sq80_data got=%h exp=9a", bus.out_data); end
    finish_hs();
    issue(2'b11, 8'h02, 8'h37, 4'd8, lat);
    total++; if (bus.out_data !== 8'h04) begin bad++; $display("FAIL sq02_data got=%h exp=04", bus.out_data); end
    finish_hs();
  endtask

  task automatic test_add();
    int lat;
    issue(2'b00, 8'hFF, 8'h01, 4'd8, lat);
    total++; if (lat !== 2) begin bad++; $display("FAIL add_latency got=%0d exp=2", lat); end
    total++; if ({bus.out_carry, bus.out_data} !== 9'h100) begin bad++; $display("FAIL add_result got=%h exp=100", {bus.out_carry, bus.out_data}); end
    finish_hs();
    issue(2'b01, 8'hFF, 8'h0F, 4'd8, lat);
    total++; if ({bus.out_carry, bus.out_data} !== 9'h0F0) begin bad++; $display("FAIL xor_result got=%h exp=0f0", {bus.out_carry, bus.out_data}); end
    total++; if (lat !== 2) begin bad++; $display("FAIL xor_latency got=%0d exp=2", lat); end
    finish_hs();
  endtask

  task automatic test_illegal_grade();
    int lat;
    issue(2'b10, 8'h57, 8'h83, 4'd1, lat);
    total++; if (lat !== 1) begin bad++; $display("FAIL badgrade_latency got=%0d exp=1", lat); end
    total++; if ({bus.out_err, bus.out_data} !== 9'h100) begin bad++; $display("FAIL badgrade_result got=%h exp=100", {bus.out_err, bus.out_data}); end
    finish_hs();
    issue(2'b10, 8'h57, 8'h83, 4'd9, lat);
    total++; if (bus.out_err !== 1'b1) begin bad++; $display("FAIL grade9_err got=%b exp=1", bus.out_err); end
    finish_hs();
    issue(2'b00, 8'h12, 8'h34, 4'd1, lat);
    total++; if ({bus.out_err, bus.out_carry, bus.out_data} !== 10'h046) begin bad++; $display("FAIL add_grade1 got=%h exp=046", {bus.out_err, bus.out_carry, bus.out_data}); end
    finish_hs();
  endtask

  task automatic test_backpressure();
    int lat;
`ifdef GF_SEQ_PERF_CNT_EN
    logic [31:0] cnt0;
    cnt0 = op_count;
`endif
    issue(2'b00, 8'h80, 8'h81, 4'd8, lat);
    for (int k = 0; k < 5; k++) begin
      total++;
      if ({bus.out_valid, bus.in_ready, bus.out_carry, bus.out_data} !== 11'h501) begin
        bad++;
        $display("FAIL bp_hold cyc=%0d got=%h exp=501", k, {bus.out_valid, bus.in_ready, bus.out_carry, bus.out_data});
      end
      @(posedge clk);
      #1;
    end
    // A request waiting during the completing handshake must not be taken that cycle.
    bus.in_valid = 1'b1;
    bus.in_op    = 2'b01;
    bus.in_a     = 8'h3C;
    bus.in_b     = 8'h0F;
    finish_hs();
    total++; if ({bus.out_valid, bus.in_ready} !== 2'b01) begin bad++; $display("FAIL bp_release got=%b exp=01", {bus.out_valid, bus.in_ready}); end
`ifdef GF_SEQ_PERF_CNT_EN
    total++; if (op_count !== cnt0 + 32'd1) begin bad++; $display("FAIL bp_count got=%0d exp=%0d", op_count, cnt0 + 32'd1); end
`endif
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL b2b_accept got=%b exp=0", bus.in_ready); end
    @(posedge clk);
    #1;
    total++; if ({bus.out_valid, bus.out_data} !== 9'h133) begin bad++; $display("FAIL b2b_result got=%h exp=133", {bus.out_valid, bus.out_data}); end
    finish_hs();
  endtask

  task automatic test_reset_mid();
    int lat;
`ifdef GF_SEQ_PERF_CNT_EN
    logic [31:0] cnt0;
    cnt0 = op_count;
`endif
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_op    = 2'b10;
    bus.in_a     = 8'h57;
    bus.in_b     = 8'h83;
    bus.in_grade = 4'd8;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    total++; if (dp_red_funct !== 1'b1) begin bad++; $display("FAIL mid_in_reduce got=%b exp=1", dp_red_funct); end
    rst = 1'b1;
    #1;
    total++; if ({bus.in_ready, bus.out_valid, dp_red_funct} !== 3'b100) begin bad++; $display("FAIL mid_reset_state got=%b exp=100", {bus.in_ready, bus.out_valid, dp_red_funct}); end
    @(posedge clk);
    #1;
    total++; if ({bus.out_valid, bus.out_data} !== 9'h000) begin bad++; $display("FAIL mid_reset_hold got=%h exp=000", {bus.out_valid, bus.out_data}); end
`ifdef GF_SEQ_PERF_CNT_EN
    total++; if (op_count !== cnt0 && op_count !== 32'd0) begin bad++; $display("FAIL mid_reset_count got=%0d exp=%0d", op_count, cnt0); end
`endif
    @(negedge clk);
    rst = 1'b0;
    issue(2'b10, 8'h57, 8'h83, 4'd8, lat);
    total++; if ({bus.out_err, bus.out_data} !== 9'h0C1) begin bad++; $display("FAIL post_reset_mul got=%h exp=0c1", {bus.out_err, bus.out_data}); end
    total++; if (lat !== 3) begin bad++; $display("FAIL post_reset_latency got=%0d exp=3", lat); end
    finish_hs();
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_op     = 2'b00;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_poly   = 9'h11B;
    bus.in_grade  = 4'd8;
    bus.out_ready = 1'b0;
    test_reset();
    test_mul();
    test_square();
    test_add();
    test_illegal_grade();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
